// File: rtl/multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_seq
// Purpose  : Operand latch, iteration counter and result capture sequencer
//            for the iterative multiply/divide datapaths.
// Revision : 1.0  initial release
// ============================================================================
module multdiv_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 16,
    parameter int DIV_CYCLES  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] counter,
    input  logic [WIDTH-1:0] mult_product,
    input  logic             mult_overflow,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic             div_exception,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [WIDTH-1:0] c_MULT_END = WIDTH'(MULT_CYCLES);
    localparam logic [WIDTH-1:0] c_DIV_END  = WIDTH'(DIV_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULT  = 2'd1,
        S_DIV   = 2'd2,
        S_DZERO = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_counter;
    logic [WIDTH-1:0] r_result;
    logic             r_exception;
    logic             r_rdy;
    logic             r_busy;

    logic w_start;
    logic w_div_zero;

    assign w_start    = ctrl_MULT | ctrl_DIV;
    // Multiply has priority, so a simultaneous divide-by-zero request is ignored.
    assign w_div_zero = ~ctrl_MULT & ctrl_DIV & (data_operandB == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_counter   <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_start) begin
                // A start always aborts whatever is running, including a terminal count.
                r_busy <= 1'b1;
                if (w_div_zero) begin
                    r_state <= S_DZERO;
                end else begin
                    r_op_a    <= data_operandA;
                    r_op_b    <= data_operandB;
                    r_counter <= '0;
                    r_state   <= ctrl_MULT ? S_MULT : S_DIV;
                end
            end else begin
                case (r_state)
                    S_MULT: begin
                        if (r_counter == c_MULT_END) begin
                            r_result    <= mult_product;
                            r_exception <= mult_overflow;
                            r_rdy       <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_counter <= r_counter + 1'b1;
                        end
                    end
                    S_DIV: begin
                        if (r_counter == c_DIV_END) begin
                            r_result    <= div_quotient;
                            r_exception <= div_exception;
                            r_rdy       <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_counter <= r_counter + 1'b1;
                        end
                    end
                    S_DZERO: begin
                        r_result    <= '0;
                        r_exception <= 1'b1;
                        r_rdy       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                    default: begin
                        r_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign op_a           = r_op_a;
    assign op_b           = r_op_b;
    assign counter        = r_counter;
    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_seq
// Purpose  : Scoreboard bench for multdiv_seq with behavioural datapath models.
// Revision : 1.0  initial release
// ============================================================================
module tb_multdiv_seq;

    localparam int c_MULT_LAT = 17;
    localparam int c_DIV_LAT  = 33;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] op_a, op_b, counter;
    logic [31:0] mult_product, div_quotient, data_result;
    logic        mult_overflow, div_exception;
    logic        data_exception, data_resultRDY, busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_rdy = 0;

    multdiv_seq #(.WIDTH(32), .MULT_CYCLES(16), .DIV_CYCLES(32)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .op_a          (op_a),
        .op_b          (op_b),
        .counter       (counter),
        .mult_product  (mult_product),
        .mult_overflow (mult_overflow),
        .div_quotient  (div_quotient),
        .div_exception (div_exception),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [32:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return {(p != {{32{p[31]}}, p[31:0]}), p[31:0]};
    endfunction

    function automatic logic [32:0] div_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] qv;
        if (b == '0) return {1'b1, 32'hFFFF_FFFF};
        qv = $signed(a) / $signed(b);
        return {(a == 32'h8000_0000 && b == 32'hFFFF_FFFF), qv};
    endfunction

    assign {mult_overflow, mult_product} = mul_model(op_a, op_b);
    assign {div_exception, div_quotient} = div_model(op_a, op_b);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && data_resultRDY) begin
            exp_t e;
            n_rdy++;
            if (q.size() == 0) begin
                check("unexpected_rdy", 64'(data_resultRDY), 64'd0);
            end else begin
                e = q.pop_front();
                check("result", 64'(data_result), 64'(e.res));
                check("exception", 64'(data_exception), 64'(e.exc));
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        int          lat;
        @(negedge clk);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        q.delete();
        if (m) begin
            r   = mul_model(a, b);
            lat = c_MULT_LAT;
        end else if (b == '0) begin
            r   = {1'b1, 32'd0};
            lat = 1;
        end else begin
            r   = div_model(a, b);
            lat = c_DIV_LAT;
        end
        q.push_back('{res: r[31:0], exc: r[32], cyc: cyc + 1 + lat});
        @(negedge clk);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles && q.size() != 0; i++) @(posedge clk);
        check("timeout", 64'(q.size()), 64'd0);
        q.delete();
        @(negedge clk);
        check("rdy_one_cycle", 64'(data_resultRDY), 64'd0);
    endtask

    task automatic wait_counter(input logic [31:0] val, input int max_cycles);
        int i;
        for (i = 0; i < max_cycles && counter != val; i++) @(negedge clk);
        check("counter_reach", 64'(counter), 64'(val));
    endtask

    initial begin
        logic [31:0] cnt_before;
        int          rdy_before;

        repeat (3) @(negedge clk);
        check("rst_counter", 64'(counter), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdy", 64'(data_resultRDY), 64'd0);
        check("rst_result", 64'({data_exception, data_result}), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Multiply with signed operand
        start(1'b1, 1'b0, 32'd7, -32'sd3);
        check("mult_busy", 64'(busy), 64'd1);
        check("mult_op_a", 64'(op_a), 64'd7);
        check("mult_op_b", 64'(op_b), 64'hFFFF_FFFD);
        wait_done(40);
        check("mult_value", 64'(data_result), 64'hFFFF_FFEB);
        check("idle_busy", 64'(busy), 64'd0);

        // Divide; a new start must not clear the held result
        start(1'b0, 1'b1, 32'd100, 32'd7);
        check("result_hold", 64'(data_result), 64'hFFFF_FFEB);
        wait_done(60);
        check("div_value", 64'(data_result), 64'd14);

        // Divide by zero: one-cycle latency, counter and operands untouched
        cnt_before = counter;
        start(1'b0, 1'b1, 32'd5, 32'd0);
        wait_done(10);
        check("dz_counter", 64'(counter), 64'(cnt_before));
        check("dz_op_a", 64'(op_a), 64'd100);

        // Restart mid-multiply: only the second operation completes
        start(1'b1, 1'b0, 32'd3, 32'd4);
        wait_counter(32'd7, 20);
        rdy_before = n_rdy;
        start(1'b1, 1'b0, 32'd5, 32'd6);
        wait_done(40);
        check("restart_value", 64'(data_result), 64'd30);
        check("restart_one_rdy", 64'(n_rdy - rdy_before), 64'd1);

        // Both controls together: multiply wins
        start(1'b1, 1'b1, 32'd6, 32'd2);
        wait_done(40);
        check("both_value", 64'(data_result), 64'd12);

        // Multiply overflow and signed divide
        start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        wait_done(40);
        start(1'b0, 1'b1, -32'sd100, 32'd7);
        wait_done(60);

        // Asynchronous reset in the middle of a divide
        start(1'b0, 1'b1, 32'd100, 32'd7);
        wait_counter(32'd10, 20);
        rdy_before = n_rdy;
        reset_n = 1'b0;
        q.delete();
        #1;
        check("arst_counter", 64'(counter), 64'd0);
        check("arst_ops", 64'({op_a, op_b}), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_result", 64'({data_exception, data_result}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (45) @(negedge clk);
        check("arst_no_rdy", 64'(n_rdy - rdy_before), 64'd0);
        check("arst_counter_hold", 64'(counter), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
